// File: rtl/data_memory_mp.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_mp
// Brief    : Shared data memory with a byte-enabled CPU port, a FIFO-buffered
//            keyboard write channel, a registered VGA read port and a key shadow.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_mp #(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 64,
    parameter int KEY_WORD      = 10,
    parameter int KB_FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cpu_we,
    input  logic [DATA_W/8-1:0]              cpu_be,
    input  logic [31:0]                      cpu_addr,
    input  logic [DATA_W-1:0]                cpu_wd,
    output logic [DATA_W-1:0]                cpu_rd,
    input  logic                             kb_valid,
    output logic                             kb_ready,
    input  logic [$clog2(DEPTH)-1:0]         kb_addr,
    input  logic [DATA_W-1:0]                kb_data,
    input  logic                             vga_req,
    input  logic [31:0]                      vga_addr,
    output logic                             vga_valid,
    output logic [DATA_W-1:0]                vga_data,
    output logic [DATA_W-1:0]                key_code,
    output logic                             key_pending,
    input  logic                             key_ack,
    output logic [$clog2(KB_FIFO_DEPTH):0]   kb_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_NB = DATA_W / 8;
    localparam int c_PW = $clog2(KB_FIFO_DEPTH);
    localparam int c_LW = c_PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [c_AW-1:0]   r_fifo_addr [KB_FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [KB_FIFO_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_LW-1:0]   r_level;

    logic              r_vga_valid;
    logic [DATA_W-1:0] r_vga_data;
    logic [DATA_W-1:0] r_key_code;
    logic              r_key_pending;

    logic [c_AW-1:0]   w_cpu_word;
    logic [c_AW-1:0]   w_vga_word;
    logic              w_cpu_in_range;
    logic              w_vga_in_range;
    logic              w_cpu_wr;
    logic              w_push;
    logic              w_pop;
    logic              w_ram_we;
    logic [c_AW-1:0]   w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_cpu_merged;
    logic              w_unused;

    assign w_cpu_word     = cpu_addr[c_AW+1:2];
    assign w_vga_word     = vga_addr[c_AW+1:2];
    assign w_cpu_in_range = (cpu_addr[31:c_AW+2] == '0);
    assign w_vga_in_range = (vga_addr[31:c_AW+2] == '0);
    assign w_unused       = ^{cpu_addr[1:0], vga_addr[1:0]};

    assign cpu_rd = w_cpu_in_range ? r_mem[w_cpu_word] : '0;

    // Any asserted cpu_we stalls the drain, even when the write itself is dropped.
    assign w_cpu_wr = cpu_we && w_cpu_in_range && (|cpu_be);
    assign kb_ready = (r_level < c_LW'(KB_FIFO_DEPTH));
    assign w_push   = kb_valid && kb_ready;
    assign w_pop    = (r_level != '0) && !cpu_we;

    always_comb begin
        w_cpu_merged = r_mem[w_cpu_word];
        for (int b = 0; b < c_NB; b++) begin
            if (cpu_be[b]) begin
                w_cpu_merged[b*8 +: 8] = cpu_wd[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = w_cpu_word;
        w_ram_wdata = w_cpu_merged;
        if (w_cpu_wr) begin
            w_ram_we = 1'b1;
        end else if (w_pop) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_fifo_addr[r_rd_ptr];
            w_ram_wdata = r_fifo_data[r_rd_ptr];
        end
    end

    // RAM and FIFO storage carry no reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= kb_addr;
            r_fifo_data[r_wr_ptr] <= kb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_valid <= 1'b0;
            r_vga_data  <= '0;
        end else begin
            r_vga_valid <= vga_req;
            if (vga_req) begin
                r_vga_data <= w_vga_in_range ? r_mem[w_vga_word] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code    <= '0;
            r_key_pending <= 1'b0;
        end else begin
            if (w_ram_we && (w_ram_addr == c_AW'(KEY_WORD))) begin
                r_key_code    <= w_ram_wdata;
                r_key_pending <= 1'b1;
            end else if (key_ack) begin
                r_key_pending <= 1'b0;
            end
        end
    end

    assign vga_valid   = r_vga_valid;
    assign vga_data    = r_vga_data;
    assign key_code    = r_key_code;
    assign key_pending = r_key_pending;
    assign kb_level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_mp
// Brief    : Directed self-checking bench for data_memory_mp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_mp;

    logic        clk;
    logic        rst_n;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        kb_valid;
    logic        kb_ready;
    logic [5:0]  kb_addr;
    logic [31:0] kb_data;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_valid;
    logic [31:0] vga_data;
    logic [31:0] key_code;
    logic        key_pending;
    logic        key_ack;
    logic [2:0]  kb_level;

    int n_checks = 0;
    int n_errors = 0;

    data_memory_mp #(
        .DATA_W(32), .DEPTH(64), .KEY_WORD(10), .KB_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
        .kb_valid(kb_valid), .kb_ready(kb_ready), .kb_addr(kb_addr), .kb_data(kb_data),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
        .key_code(key_code), .key_pending(key_pending), .key_ack(key_ack), .kb_level(kb_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        cpu_we = 1'b1; cpu_addr = addr; cpu_wd = wd; cpu_be = be;
        tick();
        cpu_we = 1'b0; cpu_be = 4'h0;
    endtask

    task automatic cpu_peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        cpu_addr = addr;
        #1;
        check(tag, cpu_rd, exp);
    endtask

    initial begin
        rst_n = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = '0; cpu_wd = '0;
        kb_valid = 1'b0; kb_addr = '0; kb_data = '0; vga_req = 1'b0; vga_addr = '0;
        key_ack = 1'b0;
        #12;
        check("rst_vga_valid", {31'd0, vga_valid}, 32'd0);
        check("rst_vga_data", vga_data, 32'd0);
        check("rst_key_code", key_code, 32'd0);
        check("rst_key_pending", {31'd0, key_pending}, 32'd0);
        check("rst_kb_level", {29'd0, kb_level}, 32'd0);
        check("rst_kb_ready", {31'd0, kb_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Byte-enabled CPU writes, then VGA read of the merged word
        cpu_write(32'h8, 32'hDEADBEEF, 4'b1111);
        cpu_write(32'h8, 32'h00001200, 4'b0010);
        cpu_peek("cpu_be_merge", 32'h8, 32'hDEAD12EF);
        vga_req = 1'b1; vga_addr = 32'h8;
        tick();
        vga_req = 1'b0;
        check("vga_valid_hit", {31'd0, vga_valid}, 32'd1);
        check("vga_data_merge", vga_data, 32'hDEAD12EF);
        tick();
        check("vga_valid_idle", {31'd0, vga_valid}, 32'd0);
        check("vga_data_hold", vga_data, 32'hDEAD12EF);

        // Fill FIFO while cpu_we (be=0, a no-op) stalls the drain
        cpu_we = 1'b1; cpu_be = 4'h0; cpu_addr = 32'h8; cpu_wd = 32'hFFFFFFFF;
        for (int i = 1; i <= 4; i++) begin
            kb_valid = 1'b1; kb_addr = 6'(i); kb_data = 32'h11 * i;
            tick();
        end
        kb_valid = 1'b0;
        check("fifo_full_level", {29'd0, kb_level}, 32'd4);
        check("fifo_full_ready", {31'd0, kb_ready}, 32'd0);
        check("cpu_be0_noop", cpu_rd, 32'hDEAD12EF);
        cpu_we = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            tick();
            check("drain_level", {29'd0, kb_level}, 32'(i));
            check("drain_ready", {31'd0, kb_ready}, 32'd1);
        end
        for (int i = 1; i <= 4; i++) cpu_peek("drain_ram", 32'(i * 4), 32'h11 * i);

        // Key shadow: set, ack, and set-wins over simultaneous ack
        kb_valid = 1'b1; kb_addr = 6'd10; kb_data = 32'h1C;
        tick();
        kb_valid = 1'b0;
        check("kb_min_latency", {29'd0, kb_level}, 32'd1);
        tick();
        check("key_code_set", key_code, 32'h1C);
        check("key_pending_set", {31'd0, key_pending}, 32'd1);
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        check("key_pending_ack", {31'd0, key_pending}, 32'd0);
        kb_valid = 1'b1; kb_data = 32'h2C;
        tick();
        kb_valid = 1'b0; key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        check("key_set_wins", {31'd0, key_pending}, 32'd1);
        check("key_code_drain2", key_code, 32'h2C);
        cpu_write(32'h28, 32'h00000300, 4'b0010);
        check("key_code_cpu_merge", key_code, 32'h0000032C);

        // Read-before-write on the VGA port
        cpu_write(32'h14, 32'h0, 4'hF);
        cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h14; cpu_wd = 32'hA5;
        vga_req = 1'b1; vga_addr = 32'h14;
        tick();
        cpu_we = 1'b0; cpu_be = 4'h0;
        check("vga_rbw_old", vga_data, 32'h0);
        tick();
        vga_req = 1'b0;
        check("vga_rbw_new", vga_data, 32'hA5);

        // Out-of-range accesses
        cpu_write(32'h0, 32'h12345678, 4'hF);
        cpu_write(32'h100, 32'hFFFFFFFF, 4'hF);
        cpu_peek("oor_cpu_rd", 32'h100, 32'h0);
        cpu_peek("oor_no_alias", 32'h0, 32'h12345678);
        vga_req = 1'b1; vga_addr = 32'h100;
        tick();
        vga_req = 1'b0;
        check("oor_vga_rd", vga_data, 32'h0);

        // Reset with three FIFO entries pending and a VGA read in flight
        for (int i = 6; i <= 8; i++) cpu_write(32'(i * 4), 32'h0, 4'hF);
        cpu_we = 1'b1; cpu_be = 4'h0; cpu_addr = 32'h0;
        for (int i = 6; i <= 8; i++) begin
            kb_valid = 1'b1; kb_addr = 6'(i); kb_data = 32'h11 * i;
            vga_req = (i == 8); vga_addr = 32'h4;
            tick();
        end
        kb_valid = 1'b0; vga_req = 1'b0;
        check("pre_rst_level", {29'd0, kb_level}, 32'd3);
        check("pre_rst_vga_valid", {31'd0, vga_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", {29'd0, kb_level}, 32'd0);
        check("mid_rst_ready", {31'd0, kb_ready}, 32'd1);
        check("mid_rst_vga_valid", {31'd0, vga_valid}, 32'd0);
        check("mid_rst_vga_data", vga_data, 32'd0);
        check("mid_rst_key_code", key_code, 32'd0);
        cpu_we = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        for (int i = 6; i <= 8; i++) cpu_peek("post_rst_no_drain", 32'(i * 4), 32'h0);
        cpu_peek("ram_retained", 32'h4, 32'h11);
        check("post_rst_pending", {31'd0, key_pending}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
